rot_pixel_feeder: RTL and testbench

- Upstream neighbour of the output pixel memory in the rotate datapath.
- Accepts one square RGB tile as a stream of 32-bit words and unpacks it into 3-byte pixels (byte order B, G, R).
- For each source pixel, computes the rotated destination byte addresses, then drives one pixel plus its three write addresses per cycle into the output memory's B/G/R write ports.

---
 rtl/rot_pkg.sv | 32 +++
 rtl/rot_addr_calc.sv | 59 +++++
 rtl/rot_pixel_feeder.sv | 180 ++++++++++++++++++
 tb/tb_rot_pixel_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rot_pkg
// Purpose  : Shared definitions for the rotate pixel feeder datapath.
//            Holds the rotation encodings, the feeder FSM states and the
//            default tile geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rot_pkg;

  // Default tile geometry. Only 4 and 8 are legal tile dimensions: both keep
  // the tile a whole number of 32-bit words and the byte addresses in 8 bits.
  localparam int TILE_DIM_DEFAULT  = 8;
  localparam int NUM_PIX_DEFAULT   = TILE_DIM_DEFAULT * TILE_DIM_DEFAULT;
  localparam int NUM_WORDS_DEFAULT = NUM_PIX_DEFAULT * 3 / 4;

  // Rotation select encodings (clockwise).
  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

  // Feeder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rpf_state_t;

endpackage : rot_pkg
`default_nettype wire

// File: rtl/rot_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : rot_addr_calc
// Purpose  : Combinational mapping of a source pixel index and a rotation
//            select to the destination blue-byte address of that pixel.
// Ports    : pix_cnt - source pixel index, row-major (y in upper bits)
//            rot_q   - latched rotation select
//            addr_b  - destination byte address of the B component (3*idx)
// Revision : 1.0 - initial release
// ============================================================================
module rot_addr_calc
  import rot_pkg::*;
#(
  parameter int TILE_DIM = TILE_DIM_DEFAULT
) (
  input  logic [2*$clog2(TILE_DIM)-1:0] pix_cnt,
  input  logic [1:0]                    rot_q,
  output logic [7:0]                    addr_b
);

  localparam int CW = $clog2(TILE_DIM);

  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic [7:0]    w_idx;

  // TILE_DIM is a power of two, so TILE_DIM-1-v is simply ~v in CW bits.
  always_comb begin
    w_x  = pix_cnt[CW-1:0];
    w_y  = pix_cnt[2*CW-1:CW];
    w_dx = w_x;
    w_dy = w_y;
    case (rot_q)
      ROT_90: begin
        w_dx = ~w_y;
        w_dy = w_x;
      end
      ROT_180: begin
        w_dx = ~w_x;
        w_dy = ~w_y;
      end
      ROT_270: begin
        w_dx = w_y;
        w_dy = ~w_x;
      end
      default: begin
        w_dx = w_x;
        w_dy = w_y;
      end
    endcase
    w_idx  = 8'({w_dy, w_dx});
    // 3*idx as shift-and-add; largest tile gives 189, so 8 bits suffice.
    addr_b = (w_idx << 1) + w_idx;
  end

endmodule : rot_addr_calc
`default_nettype wire

// File: rtl/rot_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module   : rot_pixel_feeder
// Purpose  : Unpacks a square RGB tile arriving as 32-bit words into 3-byte
//            pixels (B, G, R order) and presents each pixel together with its
//            rotated destination byte addresses to the output pixel memory.
// Ports    : I_RPF_HCLK, I_RPF_HRESET_N    - clock, async active-low reset
//            I_RPF_START, I_RPF_ROT        - tile start pulse, rotation select
//            I_RPF_RDATA/RVALID, O_RPF_RREADY - input word handshake
//            O_RPF_PIXEL_B/G/R             - pixel components
//            O_RPF_PIXEL_IN_ADDRB/G/R      - destination byte addresses
//            O_RPF_PIXEL_VALID             - new pixel this cycle
//            O_RPF_BUSY, O_RPF_DONE        - tile in progress, tile finished
// Revision : 1.0 - initial release
// ============================================================================
module rot_pixel_feeder
  import rot_pkg::*;
#(
  parameter int TILE_DIM = TILE_DIM_DEFAULT
) (
  input  logic        I_RPF_HCLK,
  input  logic        I_RPF_HRESET_N,
  input  logic        I_RPF_START,
  input  logic [1:0]  I_RPF_ROT,
  input  logic [31:0] I_RPF_RDATA,
  input  logic        I_RPF_RVALID,
  output logic        O_RPF_RREADY,
  output logic [7:0]  O_RPF_PIXEL_B,
  output logic [7:0]  O_RPF_PIXEL_G,
  output logic [7:0]  O_RPF_PIXEL_R,
  output logic [7:0]  O_RPF_PIXEL_IN_ADDRB,
  output logic [7:0]  O_RPF_PIXEL_IN_ADDRG,
  output logic [7:0]  O_RPF_PIXEL_IN_ADDRR,
  output logic        O_RPF_PIXEL_VALID,
  output logic        O_RPF_BUSY,
  output logic        O_RPF_DONE
);

  localparam int NUM_PIX   = TILE_DIM * TILE_DIM;
  localparam int NUM_WORDS = NUM_PIX * 3 / 4;
  localparam int PW        = 2 * $clog2(TILE_DIM);
  localparam int WW        = $clog2(NUM_WORDS + 1);

  localparam logic [PW-1:0] c_last_pix  = PW'(NUM_PIX - 1);
  localparam logic [WW-1:0] c_num_words = WW'(NUM_WORDS);

  rpf_state_t    r_state;
  rpf_state_t    w_state_next;
  logic [1:0]    r_rot_q;
  logic [47:0]   r_buf;        // byte 0 (oldest) in [7:0]; unused bytes kept 0
  logic [2:0]    r_cnt;
  logic [WW-1:0] r_wcnt;
  logic [PW-1:0] r_pix_cnt;

  logic [47:0]   w_buf_next;
  logic [2:0]    w_cnt_next;
  logic          w_rready;
  logic          w_accept;
  logic          w_pop;
  logic          w_last;
  logic          w_start;
  logic [7:0]    w_addr_b;

  logic [7:0]    r_pix_b;
  logic [7:0]    r_pix_g;
  logic [7:0]    r_pix_r;
  logic [7:0]    r_addr_b;
  logic [7:0]    r_addr_g;
  logic [7:0]    r_addr_r;
  logic          r_pix_valid;
  logic          r_done;

  rot_addr_calc #(
    .TILE_DIM (TILE_DIM)
  ) u_addr_calc (
    .pix_cnt (r_pix_cnt),
    .rot_q   (r_rot_q),
    .addr_b  (w_addr_b)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_start      = (r_state == IDLE) && I_RPF_START;
    w_rready     = (r_state == RUN) && (r_cnt <= 3'd2) && (r_wcnt < c_num_words);
    w_accept     = w_rready && I_RPF_RVALID;
    w_pop        = (r_state == RUN) && (r_cnt >= 3'd3);
    w_last       = w_pop && (r_pix_cnt == c_last_pix);
    case (r_state)
      IDLE:    if (I_RPF_START) w_state_next = RUN;
      RUN:     if (w_last)      w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Byte buffer: pop first (from the pre-edge contents), then append the
  // accepted word right after whatever bytes remain.
  always_comb begin
    w_buf_next = r_buf;
    w_cnt_next = r_cnt;
    if (w_pop) begin
      w_buf_next = r_buf >> 24;
      w_cnt_next = r_cnt - 3'd3;
    end
    if (w_accept) begin
      w_buf_next = w_buf_next | (48'(I_RPF_RDATA) << {w_cnt_next, 3'b000});
      w_cnt_next = w_cnt_next + 3'd4;
    end
  end

  always_ff @(posedge I_RPF_HCLK or negedge I_RPF_HRESET_N) begin
    if (!I_RPF_HRESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge I_RPF_HCLK or negedge I_RPF_HRESET_N) begin
    if (!I_RPF_HRESET_N) begin
      r_rot_q     <= 2'd0;
      r_buf       <= '0;
      r_cnt       <= 3'd0;
      r_wcnt      <= '0;
      r_pix_cnt   <= '0;
      r_pix_b     <= 8'd0;
      r_pix_g     <= 8'd0;
      r_pix_r     <= 8'd0;
      r_addr_b    <= 8'd0;
      r_addr_g    <= 8'd0;
      r_addr_r    <= 8'd0;
      r_pix_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_rot_q   <= I_RPF_ROT;
        r_buf     <= '0;
        r_cnt     <= 3'd0;
        r_wcnt    <= '0;
        r_pix_cnt <= '0;
      end else begin
        r_buf <= w_buf_next;
        r_cnt <= w_cnt_next;
        if (w_accept) begin
          r_wcnt <= r_wcnt + 1'b1;
        end
        if (w_pop) begin
          r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
        end
      end
      // Data/address outputs hold between pops; only VALID drops.
      r_pix_valid <= w_pop;
      if (w_pop) begin
        r_pix_b  <= r_buf[7:0];
        r_pix_g  <= r_buf[15:8];
        r_pix_r  <= r_buf[23:16];
        r_addr_b <= w_addr_b;
        r_addr_g <= w_addr_b + 8'd1;
        r_addr_r <= w_addr_b + 8'd2;
      end
      // Registered off the DONE state so the pulse lands one cycle after the
      // last pixel is presented.
      r_done <= (r_state == DONE);
    end
  end

  assign O_RPF_RREADY         = w_rready;
  assign O_RPF_PIXEL_B        = r_pix_b;
  assign O_RPF_PIXEL_G        = r_pix_g;
  assign O_RPF_PIXEL_R        = r_pix_r;
  assign O_RPF_PIXEL_IN_ADDRB = r_addr_b;
  assign O_RPF_PIXEL_IN_ADDRG = r_addr_g;
  assign O_RPF_PIXEL_IN_ADDRR = r_addr_r;
  assign O_RPF_PIXEL_VALID    = r_pix_valid;
  assign O_RPF_BUSY           = (r_state == RUN);
  assign O_RPF_DONE           = r_done;

endmodule : rot_pixel_feeder
`default_nettype wire

// File: tb/tb_rot_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_pixel_feeder
// Purpose  : Self-checking bench for rot_pixel_feeder (default 8x8 tile).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_pixel_feeder;

  localparam int NPIX  = 64;
  localparam int NWORD = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  rot = 2'd0;
  logic [31:0] rdata = 32'd0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [7:0]  pb, pg, pr, ab, ag, ar;
  logic        pv, busy, done;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  rot_pixel_feeder dut (
    .I_RPF_HCLK           (clk),
    .I_RPF_HRESET_N       (rst_n),
    .I_RPF_START          (start),
    .I_RPF_ROT            (rot),
    .I_RPF_RDATA          (rdata),
    .I_RPF_RVALID         (rvalid),
    .O_RPF_RREADY         (rready),
    .O_RPF_PIXEL_B        (pb),
    .O_RPF_PIXEL_G        (pg),
    .O_RPF_PIXEL_R        (pr),
    .O_RPF_PIXEL_IN_ADDRB (ab),
    .O_RPF_PIXEL_IN_ADDRG (ag),
    .O_RPF_PIXEL_IN_ADDRR (ar),
    .O_RPF_PIXEL_VALID    (pv),
    .O_RPF_BUSY           (busy),
    .O_RPF_DONE           (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte k of the tile stream used by the full-tile runs.
  function automatic logic [7:0] sb(input int k);
    return 8'((k * 53 + 17) % 256);
  endfunction

  function automatic logic [31:0] word(input int i);
    return {sb(4*i+3), sb(4*i+2), sb(4*i+1), sb(4*i)};
  endfunction

  // Destination B address of source pixel p under rotation r.
  function automatic logic [7:0] exp_addr(input int p, input logic [1:0] r);
    int x, y, dx, dy;
    x = p % 8;
    y = p / 8;
    case (r)
      2'd0:    begin dx = x;     dy = y;     end
      2'd1:    begin dx = 7 - y; dy = x;     end
      2'd2:    begin dx = 7 - x; dy = 7 - y; end
      default: begin dx = y;     dy = 7 - x; end
    endcase
    return 8'(3 * (dy * 8 + dx));
  endfunction

  function automatic logic [63:0] outs_all();
    return 64'({rready, pb, pg, pr, ab, ag, ar, pv, busy, done});
  endfunction

  typedef struct {
    logic [1:0]  rot;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [23:0] d0;   // {B,G,R} of pixel 0
    logic [7:0]  a0;   // B address of pixel 0
    logic [23:0] d1;
    logic [7:0]  a1;
  } vec_t;

  vec_t vecs[5];

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Two-word prefix of a tile: checks accept timing and the first two pixels.
  task automatic run_vec(input vec_t v, input int n);
    string s;
    s = $sformatf("vec%0d", n);
    @(posedge clk); #1;
    start = 1'b1; rot = v.rot;
    @(posedge clk); #1;
    start = 1'b0; rot = ~v.rot; rvalid = 1'b1; rdata = v.w0;
    chk({s, "_busy_rready"}, 64'({busy, rready}), 64'b11);
    @(posedge clk); #1;            // word 0 accepted
    rdata = v.w1;
    chk({s, "_novalid_yet"}, 64'(pv), 64'd0);
    @(posedge clk); #1;            // pixel 0 presented
    chk({s, "_pix0"}, 64'({pv, pb, pg, pr, ab, ag, ar}),
        64'({1'b1, v.d0, v.a0, v.a0 + 8'd1, v.a0 + 8'd2}));
    @(posedge clk); #1;            // word 1 accepted
    rvalid = 1'b0;
    @(posedge clk); #1;            // pixel 1 presented
    chk({s, "_pix1"}, 64'({pv, pb, pg, pr, ab, ag, ar}),
        64'({1'b1, v.d1, v.a1, v.a1 + 8'd1, v.a1 + 8'd2}));
    pulse_reset();
  endtask

  // Full tile with a scoreboard. gap_pct drops RVALID randomly, glitch pulses
  // START mid-tile with another rotation, abort_at >= 0 resets after that
  // many pixels.
  task automatic run_tile(input logic [1:0] r, input int gap_pct, input bit glitch,
                          input int abort_at, input string tag);
    int npix = 0, nacc = 0, ndone = 0, wi = 0, cyc = 0, post = 0;
    int last_pix_cyc = -1, done_cyc = -1, rr_viol = 0, cnt_viol = 0, cov_err = 0;
    int cov[192];
    bit acc;
    foreach (cov[i]) cov[i] = 0;
    @(posedge clk); #1;
    start = 1'b1; rot = r;
    @(posedge clk); #1;
    start = 1'b0; rot = r ^ 2'd1;
    rvalid = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
    rdata = word(wi);
    while (post < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      acc = rvalid && rready;
      if (wi >= NWORD && rready) rr_viol++;
      if (dut.r_cnt > 3'd6) cnt_viol++;
      if (pv) begin
        if (npix < NPIX)
          chk($sformatf("%s_pix%0d", tag, npix), 64'({ab, ag, ar, pb, pg, pr}),
              64'({exp_addr(npix, r), exp_addr(npix, r) + 8'd1, exp_addr(npix, r) + 8'd2,
                   sb(3*npix), sb(3*npix+1), sb(3*npix+2)}));
        if (ab < 8'd190) begin
          cov[ab]++; cov[ab+1]++; cov[ab+2]++;
        end
        last_pix_cyc = cyc;
        npix++;
        if (npix == abort_at) begin
          #1 rst_n = 1'b0;
          #1;
          chk({tag, "_async_reset_outs"}, outs_all(), 64'd0);
          start = 1'b0; rvalid = 1'b0;
          return;
        end
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (ndone > 0) post++;
      @(posedge clk); #1;
      if (acc) begin nacc++; wi++; end
      start = (glitch && cyc == 20);
      rot   = (glitch && cyc == 20) ? (r ^ 2'd2) : (r ^ 2'd1);
      rvalid = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
      rdata = word(wi);
    end
    start = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < 192; i++) if (cov[i] != 1) cov_err++;
    chk({tag, "_no_timeout"}, 64'(cyc < 3000), 64'd1);
    chk({tag, "_accepts"}, 64'(nacc), 64'(NWORD));
    chk({tag, "_pixels"}, 64'(npix), 64'(NPIX));
    chk({tag, "_done_count"}, 64'(ndone), 64'd1);
    chk({tag, "_done_after_last"}, 64'(done_cyc - last_pix_cyc), 64'd1);
    chk({tag, "_rready_after_last_word"}, 64'(rr_viol), 64'd0);
    chk({tag, "_count_le_6"}, 64'(cnt_viol), 64'd0);
    chk({tag, "_addr_cover_once"}, 64'(cov_err), 64'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'h44332211, 32'h88776655, 24'h112233, 8'd0,   24'h445566, 8'd3};
    vecs[1] = '{2'd1, 32'h44332211, 32'h88776655, 24'h112233, 8'd21,  24'h445566, 8'd45};
    vecs[2] = '{2'd2, 32'h44332211, 32'h88776655, 24'h112233, 8'd189, 24'h445566, 8'd186};
    vecs[3] = '{2'd3, 32'h44332211, 32'h88776655, 24'h112233, 8'd168, 24'h445566, 8'd144};
    vecs[4] = '{2'd0, 32'hDDCCBBAA, 32'h030201EE, 24'hAABBCC, 8'd0,   24'hDDEE01, 8'd3};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_all(), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    run_tile(2'd1, 0,  1'b0, -1, "rot90_full");
    run_tile(2'd1, 35, 1'b0, -1, "rot90_gaps");
    run_tile(2'd2, 0,  1'b1, -1, "rot180_start_glitch");
    run_tile(2'd3, 20, 1'b0, -1, "rot270_gaps");

    run_tile(2'd0, 0, 1'b0, 10, "abort");
    @(posedge clk); #1;
    chk("abort_held_outs", outs_all(), 64'd0);
    rst_n = 1'b1;
    run_tile(2'd0, 0, 1'b0, -1, "restart_rot0");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule : tb_rot_pixel_feeder
`default_nettype wire
